// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, 1 s prescaler and MM:SS BCD counter with lap freeze.
// In: clk, reset_n, start_stop, lap_reset. Out: display_bcd, running, lap_active, wrap.
module stopwatch_ctrl #(
  parameter int CLK_DIV  = 100000000,
  parameter int DIV_BITS = 27
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        lap_reset,
  output logic [15:0] display_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  localparam logic [DIV_BITS-1:0] LAST =
    DIV_BITS'(CLK_DIV - 1);

  state_t state, state_nxt;

  logic [DIV_BITS-1:0] presc;
  logic [3:0] so, st, mo, mt;
  logic [15:0] lap_q;
  logic [15:0] live;

  logic cnt_en, tick, clr, cap;
  logic c0, c1, c2, c3;

  assign live   = {mt, mo, st, so};
  assign cnt_en = (state == RUN) || (state == LAP);
  assign tick   = cnt_en && (presc == LAST);

  assign c0 = tick && (so == 4'd9);
  assign c1 = c0 && (st == 4'd5);
  assign c2 = c1 && (mo == 4'd9);
  assign c3 = c2 && (mt == 4'd5);

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_stop) state_nxt = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_nxt = PAUSE;
        end else if (lap_reset) begin
          state_nxt = LAP;
          cap       = 1'b1;
        end
      end
      LAP: begin
        if (start_stop)     state_nxt = PAUSE;
        else if (lap_reset) state_nxt = RUN;
      end
      PAUSE: begin
        if (start_stop) begin
          state_nxt = RUN;
        end else if (lap_reset) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      presc <= '0;
      so    <= '0;
      st    <= '0;
      mo    <= '0;
      mt    <= '0;
      lap_q <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= c3;
      if (cap) lap_q <= live;
      if (clr) begin
        presc <= '0;
        so    <= '0;
        st    <= '0;
        mo    <= '0;
        mt    <= '0;
      end else if (cnt_en) begin
        // Phase is kept across PAUSE, so only RUN/LAP move it.
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) so <= c0 ? 4'd0 : so + 4'd1;
        if (c0)   st <= c1 ? 4'd0 : st + 4'd1;
        if (c1)   mo <= c2 ? 4'd0 : mo + 4'd1;
        if (c2)   mt <= c3 ? 4'd0 : mt + 4'd1;
      end
    end
  end

  assign running     = cnt_en;
  assign lap_active  = (state == LAP);
  assign display_bcd = lap_active ? lap_q : live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4.
// Expected values queued before each step, popped at each sample point.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap_reset = 1'b0;
  logic [15:0] display_bcd;
  logic        running;
  logic        lap_active;
  logic        wrap;

  int total  = 0;
  int passed = 0;
  logic [18:0] exp_q[$];

  stopwatch_ctrl #(
    .CLK_DIV(4),
    .DIV_BITS(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start_stop(start_stop),
    .lap_reset(lap_reset),
    .display_bcd(display_bcd),
    .running(running),
    .lap_active(lap_active),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mmss(input int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // Push {wrap, lap_active, running, display} expected for next sample.
  task automatic exp(input logic w, input logic l,
                     input logic r, input int s);
    exp_q.push_back({w, l, r, mmss(s)});
  endtask

  task automatic chk(input string tag);
    logic [18:0] obs;
    logic [18:0] e;
    obs = {wrap, lap_active, running, display_bcd};
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s scoreboard empty obs=%h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) passed++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  task automatic press(input logic ss, input logic lr);
    start_stop = ss;
    lap_reset  = lr;
    @(negedge clk);
    start_stop = 1'b0;
    lap_reset  = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1;
    exp(0, 0, 0, 0);
    chk("in_reset");
    cyc(2);
    reset_n = 1'b1;
    exp(0, 0, 0, 0);
    chk("after_reset");

    // lap_reset ignored in IDLE, nothing counts
    press(0, 1);
    exp(0, 0, 0, 0);
    chk("idle_lap");
    cyc(8);
    exp(0, 0, 0, 0);
    chk("idle_hold");

    // start: first tick exactly 4 cycles after start edge
    press(1, 0);
    exp(0, 0, 1, 0);
    chk("start");
    cyc(3);
    exp(0, 0, 1, 0);
    chk("pre_tick");
    cyc(1);
    exp(0, 0, 1, 1);
    chk("first_tick");
    cyc(36);
    exp(0, 0, 1, 10);
    chk("ten_sec");

    // pause then clear
    press(1, 0);
    exp(0, 0, 0, 10);
    chk("pause10");
    press(0, 1);
    exp(0, 0, 0, 0);
    chk("clear");

    // pause at 00:07 with phase 2
    press(1, 0);
    cyc(29);
    press(1, 0);
    exp(0, 0, 0, 7);
    chk("pause7");
    cyc(20);
    exp(0, 0, 0, 7);
    chk("pause_hold");
    press(1, 0);
    exp(0, 0, 1, 7);
    chk("resume");
    cyc(1);
    exp(0, 0, 1, 7);
    chk("resume_p3");
    cyc(1);
    exp(0, 0, 1, 8);
    chk("resume_tick");

    // lap freeze at 00:12
    cyc(16);
    exp(0, 0, 1, 12);
    chk("at12");
    press(0, 1);
    exp(0, 1, 1, 12);
    chk("lap_enter");
    cyc(47);
    exp(0, 1, 1, 12);
    chk("lap_frozen");
    press(0, 1);
    exp(0, 0, 1, 24);
    chk("lap_release");

    // count up to 59:59 and roll over
    cyc(14299);
    exp(0, 0, 1, 3599);
    chk("at5959");
    cyc(3);
    exp(0, 0, 1, 3599);
    chk("pre_wrap");
    cyc(1);
    exp(1, 0, 1, 0);
    chk("wrap");
    cyc(1);
    exp(0, 0, 1, 0);
    chk("wrap_1cyc");
    cyc(3);
    exp(0, 0, 1, 1);
    chk("after_wrap");

    // simultaneous pulses: start_stop wins -> PAUSE
    press(1, 1);
    exp(0, 0, 0, 1);
    chk("both");
    cyc(6);
    exp(0, 0, 0, 1);
    chk("both_hold");
    press(1, 0);
    press(0, 1);
    exp(0, 1, 1, 1);
    chk("lap2");
    cyc(2);
    exp(0, 1, 1, 1);
    chk("lap2_frozen");

    // async reset in LAP
    #2;
    reset_n = 1'b0;
    #1;
    exp(0, 0, 0, 0);
    chk("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    cyc(2);
    exp(0, 0, 0, 0);
    chk("rst_idle");
    press(1, 0);
    cyc(3);
    exp(0, 0, 1, 0);
    chk("rst_presc");
    cyc(1);
    exp(0, 0, 1, 1);
    chk("rst_tick");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
